// File: rtl/cdb_arbiter.sv
// Purpose: shares one common data bus among NUM_FU result ports; round-robin, or oldest-first with CDB_ARB_AGE_EN.
// Latency: 1 cycle from grant (fu_ready_o) to broadcast on cdb_*_o; one broadcast per cycle, back-to-back.
// Backpressure: an FU holds valid/payload until fu_ready_o; flush_i or rst withholds every grant.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int ROB_IDX_W = 5,
    parameter int RD_W      = 5,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [ROB_IDX_W-1:0]          rob_head_i,
    input  logic [NUM_FU-1:0]             fu_valid_i,
    input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx_i,
    input  logic [NUM_FU*RD_W-1:0]        fu_rd_addr_i,
    input  logic [NUM_FU*DATA_W-1:0]      fu_data_i,
    output logic [NUM_FU-1:0]             fu_ready_o,
    output logic                          cdb_valid_o,
    output logic [$clog2(NUM_FU)-1:0]     cdb_fu_id_o,
    output logic [ROB_IDX_W-1:0]          cdb_rob_idx_o,
    output logic [RD_W-1:0]               cdb_rd_addr_o,
    output logic [DATA_W-1:0]             cdb_data_o
);

    localparam int FU_ID_W = $clog2(NUM_FU);

    logic [FU_ID_W-1:0]   r_rr_ptr;
    logic                 r_cdb_valid;
    logic [FU_ID_W-1:0]   r_cdb_fu_id;
    logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
    logic [RD_W-1:0]      r_cdb_rd_addr;
    logic [DATA_W-1:0]    r_cdb_data;

    logic                 w_found;
    logic                 w_grant;
    logic [FU_ID_W-1:0]   w_win;
    logic [FU_ID_W-1:0]   w_idx;

`ifdef CDB_ARB_AGE_EN
    logic [ROB_IDX_W-1:0] w_age;
    logic [ROB_IDX_W-1:0] w_best_age;
`else
    // rob_head_i only matters for the oldest-first policy
    logic                 w_unused_rob_head;
    assign w_unused_rob_head = ^rob_head_i;
`endif

    // Requester visited at position offs of the scan starting at base, wrapping modulo NUM_FU
    function automatic logic [FU_ID_W-1:0] rr_idx(input logic [FU_ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_FU) begin
            s = s - NUM_FU;
        end
        return FU_ID_W'(s);
    endfunction

    // Pick the winner by scanning requesters in pointer order; with ages, strict '<' keeps the earliest in scan order on a tie
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
`ifdef CDB_ARB_AGE_EN
        w_age      = '0;
        w_best_age = '0;
`endif
        for (int k = 0; k < NUM_FU; k++) begin
            w_idx = rr_idx(r_rr_ptr, k);
`ifdef CDB_ARB_AGE_EN
            w_age = fu_rob_idx_i[32'(w_idx)*ROB_IDX_W +: ROB_IDX_W] - rob_head_i;
            if (fu_valid_i[w_idx] && (!w_found || (w_age < w_best_age))) begin
                w_found    = 1'b1;
                w_win      = w_idx;
                w_best_age = w_age;
            end
`else
            if (fu_valid_i[w_idx] && !w_found) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
`endif
        end
    end

    // Flush and reset suppress the grant so nothing is consumed that cycle
    assign w_grant    = w_found && !flush_i && !rst;
    assign fu_ready_o = w_grant ? (NUM_FU'(1) << w_win) : '0;

    // Register the granted result onto the bus and advance the pointer past the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_fu_id   <= '0;
            r_cdb_rob_idx <= '0;
            r_cdb_rd_addr <= '0;
            r_cdb_data    <= '0;
        end else begin
            r_cdb_valid <= w_grant;
            if (w_grant) begin
                r_rr_ptr      <= (w_win == FU_ID_W'(NUM_FU - 1)) ? '0 : w_win + 1'b1;
                r_cdb_fu_id   <= w_win;
                r_cdb_rob_idx <= fu_rob_idx_i[32'(w_win)*ROB_IDX_W +: ROB_IDX_W];
                r_cdb_rd_addr <= fu_rd_addr_i[32'(w_win)*RD_W +: RD_W];
                r_cdb_data    <= fu_data_i[32'(w_win)*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid_o   = r_cdb_valid;
    assign cdb_fu_id_o   = r_cdb_fu_id;
    assign cdb_rob_idx_o = r_cdb_rob_idx;
    assign cdb_rd_addr_o = r_cdb_rd_addr;
    assign cdb_data_o    = r_cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized traffic.
// A behavioural model ranks requesters by scan distance (plus age when CDB_ARB_AGE_EN is defined).
// Outputs are sampled #1 after the driving negedge (grant) and at the negedge after the posedge (bus).
module tb_cdb_arbiter;

    localparam int N   = 4;
    localparam int RW  = 5;
    localparam int DW  = 5;
    localparam int XW  = 32;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic [RW-1:0]   rob_head;
    logic [N-1:0]    fu_valid;
    logic [N*RW-1:0] fu_rob_idx;
    logic [N*DW-1:0] fu_rd_addr;
    logic [N*XW-1:0] fu_data;
    logic [N-1:0]    fu_ready;
    logic            cdb_valid;
    logic [IDW-1:0]  cdb_fu_id;
    logic [RW-1:0]   cdb_rob_idx;
    logic [DW-1:0]   cdb_rd_addr;
    logic [XW-1:0]   cdb_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: rotation pointer and the expected bus contents
    int            m_ptr  = 0;
    logic          m_vld  = 1'b0;
    int            m_id   = 0;
    logic [RW-1:0] m_rob  = '0;
    logic [DW-1:0] m_rd   = '0;
    logic [XW-1:0] m_data = '0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .rob_head_i    (rob_head),
        .fu_valid_i    (fu_valid),
        .fu_rob_idx_i  (fu_rob_idx),
        .fu_rd_addr_i  (fu_rd_addr),
        .fu_data_i     (fu_data),
        .fu_ready_o    (fu_ready),
        .cdb_valid_o   (cdb_valid),
        .cdb_fu_id_o   (cdb_fu_id),
        .cdb_rob_idx_o (cdb_rob_idx),
        .cdb_rd_addr_o (cdb_rd_addr),
        .cdb_data_o    (cdb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest rank wins: rank = distance from pointer, preceded by age when oldest-first is built in
    function automatic int model_winner();
        int best     = -1;
        int best_key = 0;
        int key;
        if (rst || flush_i) return -1;
        for (int i = 0; i < N; i++) begin
            if (fu_valid[i]) begin
                key = (i - m_ptr + N) % N;
`ifdef CDB_ARB_AGE_EN
                key = key + N * ((int'(fu_rob_idx[i*RW +: RW]) - int'(rob_head) + (1 << RW)) % (1 << RW));
`endif
                if (best < 0 || key < best_key) begin
                    best     = i;
                    best_key = key;
                end
            end
        end
        return best;
    endfunction

    // One clock: check the grant, advance the model at the edge, check the bus at the next negedge
    task automatic tick(input string tag);
        int           w;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        one = 1;
        #1;
        w = model_winner();
        exp_rdy = (w >= 0) ? (one << w) : '0;
        chk({tag, ".ready"}, 32'(fu_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_vld = 1'b0; m_id = 0; m_rob = '0; m_rd = '0; m_data = '0;
        end else begin
            m_vld = (w >= 0);
            if (w >= 0) begin
                m_id   = w;
                m_rob  = fu_rob_idx[w*RW +: RW];
                m_rd   = fu_rd_addr[w*DW +: DW];
                m_data = fu_data[w*XW +: XW];
                m_ptr  = (w + 1) % N;
            end
        end
        @(negedge clk);
        if (w >= 0) fu_valid[w] = 1'b0;
        chk({tag, ".cdb_valid"}, 32'(cdb_valid), 32'(m_vld));
        chk({tag, ".cdb_fu_id"}, 32'(cdb_fu_id), 32'(m_id));
        chk({tag, ".cdb_rob"},   32'(cdb_rob_idx), 32'(m_rob));
        chk({tag, ".cdb_rd"},    32'(cdb_rd_addr), 32'(m_rd));
        chk({tag, ".cdb_data"},  cdb_data, m_data);
    endtask

    task automatic set_fu(input int i, input logic [RW-1:0] rob, input logic [DW-1:0] rd, input logic [XW-1:0] d);
        fu_valid[i]            = 1'b1;
        fu_rob_idx[i*RW +: RW] = rob;
        fu_rd_addr[i*DW +: DW] = rd;
        fu_data[i*XW +: XW]    = d;
    endtask

    // Idle FUs raise a fresh request with probability pct percent; pending ones keep their payload
    task automatic refill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!fu_valid[i] && int'($urandom_range(99)) < pct) begin
                set_fu(i, RW'($urandom), DW'($urandom), $urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; rob_head = '0;
        fu_valid = '0; fu_rob_idx = '0; fu_rd_addr = '0; fu_data = '0;
        @(negedge clk);
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick("idle");

        // Single requester FU2
        set_fu(2, 5'd7, 5'd3, 32'hDEADBEEF);
        #1;
        chk("fu2_ready", 32'(fu_ready), 32'h4);
        tick("fu2");
        chk("fu2_id",   32'(cdb_fu_id), 32'd2);
        chk("fu2_rob",  32'(cdb_rob_idx), 32'd7);
        chk("fu2_rd",   32'(cdb_rd_addr), 32'd3);
        chk("fu2_data", cdb_data, 32'hDEADBEEF);

        // All FUs valid continuously, starting under reset
        rst = 1'b1;
        refill(100);
        tick("allv_rst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            refill(100);
            tick("allv");
            chk("allv_order", 32'(cdb_fu_id), 32'(k % N));
            chk("allv_vld",   32'(cdb_valid), 32'd1);
        end

        // FU3 granted, pointer wraps so FU0 beats FU3
        fu_valid = '0;
        rst = 1'b1;
        tick("wrap_rst");
        rst = 1'b0;
        set_fu(3, 5'd9, 5'd1, 32'h3333_0000);
        tick("wrap_fu3");
        set_fu(0, 5'd10, 5'd2, 32'h0000_0001);
        set_fu(3, 5'd11, 5'd4, 32'h3333_0001);
        #1;
        chk("wrap_ready", 32'(fu_ready), 32'h1);
        tick("wrap_fu0");
        chk("wrap_id", 32'(cdb_fu_id), 32'd0);
        tick("wrap_fu3b");
        chk("wrap_id2", 32'(cdb_fu_id), 32'd3);

        // Flush withholds the grant for a cycle
        set_fu(1, 5'd12, 5'd5, 32'h1111_2222);
        flush_i = 1'b1;
        tick("flush");
        chk("flush_vld", 32'(cdb_valid), 32'd0);
        flush_i = 1'b0;
        #1;
        chk("post_flush_ready", 32'(fu_ready), 32'h2);
        tick("post_flush");
        chk("post_flush_id", 32'(cdb_fu_id), 32'd1);

`ifdef CDB_ARB_AGE_EN
        // Oldest first: head 30, FU1 rob 31 (age 1) beats FU0 rob 2 (age 4)
        fu_valid = '0;
        rst = 1'b1;
        tick("age_rst");
        rst = 1'b0;
        rob_head = 5'd30;
        set_fu(0, 5'd2,  5'd6, 32'hA0A0_A0A0);
        set_fu(1, 5'd31, 5'd7, 32'hB1B1_B1B1);
        tick("age1");
        chk("age1_id", 32'(cdb_fu_id), 32'd1);
        tick("age2");
        chk("age2_id", 32'(cdb_fu_id), 32'd0);
`endif

        // Random traffic with occasional flush and mid-stream reset
        for (int k = 0; k < 400; k++) begin
            refill(40);
            flush_i  = ($urandom_range(9) == 0);
            rst      = ($urandom_range(49) == 0);
            rob_head = RW'($urandom);
            tick("rnd");
        end
        rst = 1'b0;
        flush_i = 1'b0;
        for (int k = 0; k < 6; k++) tick("drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
